cpu_result_merge: RTL and testbench

Parametrised N-channel writeback merger for late-arriving CPU results: memory reads, aux-bus reads, divider and FPU. It generalises the fixed single-stream read path. Each source gets a private FIFO so that non-stallable producers never lose a result, and a configurable arbiter selects one result per cycle. The output drives the combine stage's `mem_ready`/`mem_dest`/`mem_result` write port into the register file.

---
 rtl/cpu_result_merge.sv | 127 ++++++++++++
 tb/tb_cpu_result_merge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_merge.sv
// N-channel writeback merger: per-source FIFOs with a bypass path and a
// fixed-priority or round-robin arbiter driving a registered write port.
module cpu_result_merge #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ARB_MODE   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      in_valid,
    input  logic [NUM_CH*32-1:0]   in_data,
    input  logic [NUM_CH*5-1:0]    in_dest,
    output logic                   mem_ready,
    output logic [4:0]             mem_dest,
    output logic [31:0]            mem_result,
    output logic                   busy,
    output logic [NUM_CH-1:0]      overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(NUM_CH);

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_mem   [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr     [NUM_CH];
    logic [PW-1:0] rd_ptr     [NUM_CH];
    logic [PW-1:0] wr_ptr_nxt [NUM_CH];
    logic [PW-1:0] rd_ptr_nxt [NUM_CH];
    logic [CW-1:0] rr;

    entry_t        live [NUM_CH];
    entry_t        head [NUM_CH];
    logic [NUM_CH-1:0] live_vld, empty, full, cand, grant, push, pop, drop;
    logic          gnt_any;
    logic [CW-1:0] gnt_idx;
    entry_t        gnt_entry;
    logic          busy_nxt;

    // Per-channel status and candidate selection (FIFO head beats live input)
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            live[k].dest = in_dest[5*k +: 5];
            live[k].data = in_data[32*k +: 32];
            live_vld[k]  = in_valid[k] && (in_dest[5*k +: 5] != 5'd0);
            empty[k]     = (wr_ptr[k] == rd_ptr[k]);
            full[k]      = (wr_ptr[k][PW-1] != rd_ptr[k][PW-1]) &&
                           (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
            head[k]      = fifo_mem[k][rd_ptr[k][AW-1:0]];
            cand[k]      = !empty[k] || live_vld[k];
        end
    end

    // Arbiter: search starts at channel 0 or at the round-robin pointer
    always_comb begin
        logic [CW-1:0] sel;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sel     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 0)
                sel = CW'(i);
            else
                sel = CW'((int'(rr) + i) % NUM_CH);
            if (!gnt_any && cand[sel]) begin
                gnt_any = 1'b1;
                gnt_idx = sel;
            end
        end
        gnt_entry = empty[gnt_idx] ? live[gnt_idx] : head[gnt_idx];
    end

    // Push/pop bookkeeping; a full FIFO still accepts when it pops this cycle
    always_comb begin
        busy_nxt = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            grant[k]      = gnt_any && (gnt_idx == CW'(k));
            pop[k]        = grant[k] && !empty[k];
            push[k]       = live_vld[k] && !(grant[k] && empty[k]);
            drop[k]       = push[k] && full[k] && !pop[k];
            wr_ptr_nxt[k] = wr_ptr[k] + PW'(push[k] && !drop[k]);
            rd_ptr_nxt[k] = rd_ptr[k] + PW'(pop[k]);
            busy_nxt      = busy_nxt || (wr_ptr_nxt[k] != rd_ptr_nxt[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ready  <= 1'b0;
            mem_dest   <= '0;
            mem_result <= '0;
            busy       <= 1'b0;
            overflow   <= '0;
            rr         <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            mem_ready <= gnt_any;
            if (gnt_any) begin
                mem_dest   <= gnt_entry.dest;
                mem_result <= gnt_entry.data;
            end
            busy     <= busy_nxt;
            overflow <= overflow | drop;
            if (ARB_MODE != 0 && gnt_any)
                rr <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= wr_ptr_nxt[k];
                rd_ptr[k] <= rd_ptr_nxt[k];
            end
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k] && !drop[k])
                fifo_mem[k][wr_ptr[k][AW-1:0]] <= live[k];
        end
    end

endmodule

// File: tb/tb_cpu_result_merge.sv
// Bench for cpu_result_merge: fixed-priority and round-robin instances share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_cpu_result_merge;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    in_valid;
    logic [NCH*32-1:0] in_data;
    logic [NCH*5-1:0]  in_dest;

    logic        fp_ready, rr_ready, fp_busy, rr_busy;
    logic [4:0]  fp_dest, rr_dest;
    logic [31:0] fp_res, rr_res;
    logic [3:0]  fp_ovf, rr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = fixed priority, 1 = round robin
    logic [36:0] mq [8][$];
    int          rr_m      [2];
    logic        exp_ready [2];
    logic [4:0]  exp_dest  [2];
    logic [31:0] exp_res   [2];
    logic        exp_busy  [2];
    logic [3:0]  exp_ovf   [2];

    logic [36:0] fp_log [$];
    logic [36:0] rr_log [$];

    cpu_result_merge #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) u_fp (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_dest(in_dest), .mem_ready(fp_ready), .mem_dest(fp_dest),
        .mem_result(fp_res), .busy(fp_busy), .overflow(fp_ovf)
    );

    cpu_result_merge #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_dest(in_dest), .mem_ready(rr_ready), .mem_dest(rr_dest),
        .mem_result(rr_res), .busy(rr_busy), .overflow(rr_ovf)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic [3:0]  live;
            logic [36:0] e;
            int          g;
            if (reset) begin
                for (int k = 0; k < NCH; k++) mq[m*4+k].delete();
                rr_m[m] = 0; exp_ready[m] = 1'b0; exp_dest[m] = '0;
                exp_res[m] = '0; exp_busy[m] = 1'b0; exp_ovf[m] = '0;
            end else begin
                g = -1;
                for (int k = 0; k < NCH; k++)
                    live[k] = in_valid[k] && (in_dest[5*k +: 5] != 5'd0);
                for (int i = 0; i < NCH; i++) begin
                    int k;
                    k = (m == 0) ? i : (rr_m[m] + i) % NCH;
                    if (g < 0 && (mq[m*4+k].size() > 0 || live[k])) g = k;
                end
                exp_ready[m] = (g >= 0);
                if (g >= 0) begin
                    if (mq[m*4+g].size() > 0) begin
                        e = mq[m*4+g].pop_front();
                    end else begin
                        e = {in_dest[5*g +: 5], in_data[32*g +: 32]};
                        live[g] = 1'b0;
                    end
                    exp_dest[m] = e[36:32];
                    exp_res[m]  = e[31:0];
                    if (m == 1) rr_m[m] = (g + 1) % NCH;
                end
                for (int k = 0; k < NCH; k++) begin
                    if (live[k]) begin
                        if (mq[m*4+k].size() < DEPTH)
                            mq[m*4+k].push_back({in_dest[5*k +: 5], in_data[32*k +: 32]});
                        else
                            exp_ovf[m][k] = 1'b1;
                    end
                end
                exp_busy[m] = 1'b0;
                for (int k = 0; k < NCH; k++)
                    if (mq[m*4+k].size() > 0) exp_busy[m] = 1'b1;
            end
        end
    endtask

    task automatic check_dut(input string p, input int m, input logic rdy, input logic [4:0] d,
                             input logic [31:0] r, input logic b, input logic [3:0] o);
        check_eq({p, ".ready"},  32'(rdy), 32'(exp_ready[m]));
        check_eq({p, ".dest"},   32'(d),   32'(exp_dest[m]));
        check_eq({p, ".result"}, r,        exp_res[m]);
        check_eq({p, ".busy"},   32'(b),   32'(exp_busy[m]));
        check_eq({p, ".ovf"},    32'(o),   32'(exp_ovf[m]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_dut("fp", 0, fp_ready, fp_dest, fp_res, fp_busy, fp_ovf);
        check_dut("rr", 1, rr_ready, rr_dest, rr_res, rr_busy, rr_ovf);
        if (fp_ready) fp_log.push_back({fp_dest, fp_res});
        if (rr_ready) rr_log.push_back({rr_dest, rr_res});
    endtask

    task automatic idle();
        in_valid = '0; in_data = '0; in_dest = '0;
    endtask

    task automatic drive(input int k, input logic [4:0] d, input logic [31:0] x);
        in_valid[k]       = 1'b1;
        in_dest[5*k +: 5] = d;
        in_data[32*k +: 32] = x;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0;
        fp_log.delete(); rr_log.delete();
    endtask

    initial begin
        int cnt;
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst.fp_ready", 32'(fp_ready), 32'd0);
        check_eq("rst.rr_busy",  32'(rr_busy),  32'd0);
        check_eq("rst.fp_ovf",   32'(fp_ovf),   32'd0);
        check_eq("rst.rr_dest",  32'(rr_dest),  32'd0);

        // Single result through the bypass
        for (int i = 0; i < 4; i++) tick();
        drive(2, 5'd7, 32'hDEADBEEF);
        tick();
        check_eq("single.ready",  32'(rr_ready), 32'd1);
        check_eq("single.dest",   32'(rr_dest),  32'd7);
        check_eq("single.result", rr_res,        32'hDEADBEEF);
        check_eq("single.busy",   32'(rr_busy),  32'd0);
        idle(); tick();
        check_eq("single.ready_off", 32'(rr_ready), 32'd0);
        check_eq("single.dest_hold", 32'(rr_dest),  32'd7);

        // Round-robin contention, repeated back to back
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NCH; k++) drive(k, 5'(k + 1), 32'(100 + k));
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) tick();
        check_eq("rr.count", 32'(rr_log.size()), 32'd8);
        for (int i = 0; i < rr_log.size() && i < 8; i++)
            check_eq("rr.order", 32'(rr_log[i][36:32]), 32'((i % 4) + 1));

        // Fixed-priority starvation of ch1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            drive(0, 5'(10 + i), 32'(i));
            if (i == 0) drive(1, 5'd9, 32'h99);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        check_eq("starve.count", 32'(fp_log.size()), 32'd7);
        if (fp_log.size() == 7)
            check_eq("starve.ch1_last", 32'(fp_log[6][36:32]), 32'd9);
        check_eq("starve.ovf", 32'(fp_ovf), 32'd0);

        // Overflow on ch3 behind a saturating ch0
        do_reset();
        drive(3, 5'd20, 32'h20);
        tick();
        for (int i = 1; i < 9; i++) begin
            idle();
            drive(0, 5'd1, 32'(i));
            if (i < 6) drive(3, 5'(20 + i), 32'(32'h20 + i));
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) tick();
        cnt = 0;
        foreach (fp_log[i]) begin
            if (fp_log[i][36:32] >= 5'd20) cnt++;
            if (fp_log[i][36:32] == 5'd25) check_eq("ovf.dropped_seen", 32'd1, 32'd0);
        end
        check_eq("ovf.kept", 32'(cnt), 32'd5);
        check_eq("ovf.flag", 32'(fp_ovf[3]), 32'd1);

        // Per-channel order and r0 discard
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            drive(0, 5'd10, 32'hA0);
            drive(1, (i == 0) ? 5'd5 : (i == 1) ? 5'd0 : 5'd6, 32'(i + 1));
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) tick();
        cnt = 0;
        foreach (fp_log[i]) begin
            if (fp_log[i][36:32] == 5'd0) check_eq("r0.output", 32'd1, 32'd0);
            if (fp_log[i][36:32] == 5'd5 || fp_log[i][36:32] == 5'd6) begin
                check_eq("order.dest", 32'(fp_log[i][36:32]), (cnt == 0) ? 32'd5 : 32'd6);
                check_eq("order.data", fp_log[i][31:0], (cnt == 0) ? 32'd1 : 32'd3);
                cnt++;
            end
        end
        check_eq("order.count", 32'(cnt), 32'd2);

        // Reset with three FIFOs partially filled
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NCH; k++) drive(k, 5'(k + 2 + 4*i), 32'(k * 16 + i));
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst.ready", 32'(fp_ready), 32'd0);
        check_eq("midrst.busy",  32'(rr_busy),  32'd0);
        check_eq("midrst.ovf",   32'(fp_ovf),   32'd0);
        fp_log.delete(); rr_log.delete();
        for (int i = 0; i < 8; i++) tick();
        check_eq("midrst.stale_fp", 32'(fp_log.size()), 32'd0);
        check_eq("midrst.stale_rr", 32'(rr_log.size()), 32'd0);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 99) < 35)
                    drive(k, 5'($urandom_range(0, 31)), $urandom);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
